seg7_scan_sched: RTL and testbench
==================================

Name: seg7_scan_sched

Overview:
Time-multiplexing scheduler for the board's 6-digit common-anode seven-segment display. It holds one 5-bit digit code per position, loaded through a simple write port. It walks the digits round-robin with a programmable slot length and a dead-time blank between digits to suppress ghosting. It drives the active-low segment bus {a,b,c,d,e,f,g,dp} and the active-low digit-select bus seg7_decode, so top-levels no longer hand-roll scan counters.

Parameters:
NUM_DIGITS, 6, number of scanned digits (1..6); seg7_decode bits at or above NUM_DIGITS held high
SCAN_DIV, 1024, clk cycles per digit slot, including blank time
BLANK_CYC, 16, cycles at the start of each slot with all segments and digits off; must satisfy 1 <= BLANK_CYC < SCAN_DIV

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
enable  input  1  1 = scan running; 0 = display dark
wr_en  input  1  write strobe, one digit per cycle
wr_addr  input  3  digit index for the write
wr_data  input  5  bit4 = decimal point, bits3:0 = hex value 0-F
seg_n  output  8  {a,b,c,d,e,f,g,dp}, active-low
seg7_decode  output  6  digit select, active-low, one-cold while driving
frame_tick  output  1  one-cycle pulse at the start of each full frame

Behaviour:
- Reset (async assert, sync release): digit RAM all 0, state IDLE, slot counter 0, digit index 0, seg_n=8'hFF, seg7_decode=6'h3F, frame_tick=0.
- FSM states: IDLE, BLANK, DRIVE.
- IDLE: outputs dark. When enable=1, go to BLANK with index 0 on the next edge and pulse frame_tick on that same edge.
- BLANK: outputs dark for BLANK_CYC cycles. On the last BLANK cycle, latch the shadow code for the current digit from RAM. Then go to DRIVE.
- DRIVE: seg7_decode[index]=0 and all other bits 1. seg_n = ~decode(shadow). Lasts SCAN_DIV-BLANK_CYC cycles.
- End of DRIVE: index increments, wrapping NUM_DIGITS-1 -> 0, and the FSM returns to BLANK. On the wrap, frame_tick pulses for one cycle on the same edge as the BLANK entry.
- Slot counter: width $clog2(SCAN_DIV). Cleared on every state change.
- Hex decode, active-high {a..g} before inversion:
  - 0:1111110, 1:0110000, 2:1101101, 3:1111001, 4:0110011, 5:1011011, 6:1011111, 7:1110000
  - 8:1111111, 9:1111011, A:1110111, b:0011111, C:1001110, d:0111101, E:1001111, F:1000111
  - dp = wr_data[4].
- Writes:
  - Take effect in RAM on the edge where wr_en=1.
  - wr_addr >= NUM_DIGITS is ignored.
  - A write to the digit currently in DRIVE does not change the outputs until that digit's next slot (shadow latch).
  - A write landing on the same edge as the shadow latch is captured by the shadow.
- enable deasserted in any state: next edge goes to IDLE, outputs dark, index reset to 0, RAM retained.
- enable re-asserted: scan restarts at digit 0 with a frame_tick.
- Outputs are registered. No combinational path from inputs to outputs.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- When defined: a digit whose value is 0 and whose dp bit is 0 is blanked (seg_n=8'hFF) if every higher-index digit is also 0 with dp 0. Digit 0 is never blanked. Its digit select still asserts and timing is unchanged. The blank decision is made at the shadow latch.
- When undefined: all digits always display.

Test Plan:
- Reset mid-DRIVE (rst pulsed between edges) -> seg_n=8'hFF and seg7_decode=6'h3F immediately; after release with enable=1, frame_tick pulses one cycle later.
- SCAN_DIV=8, BLANK_CYC=2, write digits 0..5 = 1,2,3,4,5,6 -> per digit: 2 dark cycles, then 6 cycles of seg7_decode=~(1<<i) with the correct code (digit0 seg_n=8'b10011111). frame_tick every 48 cycles.
- Write wr_addr=7, data=5'h08 -> RAM unchanged; no digit ever shows 8.
- Write digit 2 = 5'h1A while digit 2 is in DRIVE -> outputs keep the old code for that slot; the next frame shows seg_n=8'b00010000 (A with dp).
- enable dropped for 3 cycles mid-frame -> dark within 1 cycle; on re-enable, the scan restarts at digit 0 with a frame_tick and the RAM contents are intact.
- With SEG7_LEADING_ZERO_BLANK_EN, digits {5..0} = 0,0,0,4,0,7 -> digits 5-3 dark, digits 2-0 show 4,0,7. Without the macro, all six digits are shown.

Source files
------------

// File: rtl/seg7_scan_sched.sv
// seg7_scan_sched
// ---------------------------------------------------------------------------
// Time-multiplexing scheduler for a common-anode seven-segment display with
// up to six digits. Digit codes are stored in a small register file written
// through a one-digit-per-cycle write port. The scanner walks the digits
// round-robin: each slot is SCAN_DIV clocks long, starting with BLANK_CYC
// dark clocks (anti-ghosting) followed by the drive phase for that digit.
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   enable       1 = scan running, 0 = display dark (index back to digit 0)
//   wr_en        write strobe, one digit per cycle
//   wr_addr      digit index for the write (>= NUM_DIGITS ignored)
//   wr_data      {dp, hex[3:0]}
//   seg_n        {a,b,c,d,e,f,g,dp}, active-low, registered
//   seg7_decode  digit select, active-low, one-cold while driving, registered
//   frame_tick   one-cycle pulse on the edge that starts digit 0's slot
//
// Parameters
//   NUM_DIGITS   number of scanned digits (1..6); unused select bits stay high
//   SCAN_DIV     clocks per digit slot, blank time included
//   BLANK_CYC    dark clocks at the start of each slot, 1 <= BLANK_CYC < SCAN_DIV
//
// Optional build macro
//   SEG7_LEADING_ZERO_BLANK_EN  blank leading zero digits (value 0, dp 0,
//                               with all higher digits also 0/dp 0); digit 0
//                               is never blanked. Select timing is unchanged.
//
// Handshake: there is no flow control. A write is accepted on every edge
// where wr_en=1 and wr_addr < NUM_DIGITS; outputs change only on clk edges.
// ---------------------------------------------------------------------------
module seg7_scan_sched #(
  parameter int NUM_DIGITS = 6,
  parameter int SCAN_DIV   = 1024,
  parameter int BLANK_CYC  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [4:0] wr_data,
  output logic [7:0] seg_n,
  output logic [5:0] seg7_decode,
  output logic       frame_tick
);

  localparam int CW = $clog2(SCAN_DIV);

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(SCAN_DIV - BLANK_CYC - 1);
  localparam logic [2:0]    IDX_LAST   = 3'(NUM_DIGITS - 1);
  localparam logic [2:0]    ADDR_LIM   = 3'(NUM_DIGITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] slot_cnt;
  logic [2:0]    idx;
  logic [4:0]    shadow;
  logic          shadow_blank;

  logic [4:0]    ram [NUM_DIGITS];
  logic [4:0]    ram_view [NUM_DIGITS];
  logic          wr_ok;
  logic [4:0]    cur_code;
  logic          lz_blank;

  // Active-high {a,b,c,d,e,f,g} pattern for a hex digit.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  // Active-low segment bus for a stored code, or all-off when blanked.
  function automatic logic [7:0] seg_of(input logic [4:0] code, input logic blank);
    logic [7:0] s;
    if (blank) s = 8'hFF;
    else       s = ~{hex7(code[3:0]), code[4]};
    return s;
  endfunction

  // Active-low one-cold select; indices above NUM_DIGITS-1 never occur, so
  // the unused upper select lines stay high.
  function automatic logic [5:0] sel_of(input logic [2:0] i);
    return ~(6'b000001 << i);
  endfunction

  assign wr_ok = wr_en && (wr_addr < ADDR_LIM);

  // Digit register file. Contents survive enable toggling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) ram[i] <= 5'd0;
    end else if (wr_ok) begin
      ram[wr_addr] <= wr_data;
    end
  end

  // RAM contents as they will be after this edge: a write landing on the
  // same edge as the shadow latch is forwarded so the shadow captures it.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      ram_view[i] = ram[i];
      if (wr_ok && (wr_addr == 3'(i))) ram_view[i] = wr_data;
    end
  end

  assign cur_code = ram_view[idx];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Blank when this digit and every higher digit is a plain zero.
  always_comb begin
    lz_blank = (idx != 3'd0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((3'(i) >= idx) && (ram_view[i] != 5'd0)) lz_blank = 1'b0;
    end
  end
`else
  assign lz_blank = 1'b0;
`endif

  // Scan FSM. All outputs are registered here; enable low forces IDLE from
  // any state on the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      slot_cnt     <= '0;
      idx          <= 3'd0;
      shadow       <= 5'd0;
      shadow_blank <= 1'b0;
      seg_n        <= 8'hFF;
      seg7_decode  <= 6'h3F;
      frame_tick   <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (!enable) begin
        state       <= IDLE;
        slot_cnt    <= '0;
        idx         <= 3'd0;
        seg_n       <= 8'hFF;
        seg7_decode <= 6'h3F;
      end else begin
        case (state)
          IDLE: begin
            state       <= BLANK;
            slot_cnt    <= '0;
            idx         <= 3'd0;
            frame_tick  <= 1'b1;
            seg_n       <= 8'hFF;
            seg7_decode <= 6'h3F;
          end

          BLANK: begin
            if (slot_cnt == BLANK_LAST) begin
              // Shadow latch: the code shown for the whole drive phase.
              state        <= DRIVE;
              slot_cnt     <= '0;
              shadow       <= cur_code;
              shadow_blank <= lz_blank;
              seg_n        <= seg_of(cur_code, lz_blank);
              seg7_decode  <= sel_of(idx);
            end else begin
              slot_cnt <= slot_cnt + 1'b1;
            end
          end

          DRIVE: begin
            if (slot_cnt == DRIVE_LAST) begin
              state       <= BLANK;
              slot_cnt    <= '0;
              seg_n       <= 8'hFF;
              seg7_decode <= 6'h3F;
              if (idx == IDX_LAST) begin
                idx        <= 3'd0;
                frame_tick <= 1'b1;
              end else begin
                idx <= idx + 3'd1;
              end
            end else begin
              slot_cnt    <= slot_cnt + 1'b1;
              seg_n       <= seg_of(shadow, shadow_blank);
              seg7_decode <= sel_of(idx);
            end
          end

          default: begin
            state       <= IDLE;
            slot_cnt    <= '0;
            idx         <= 3'd0;
            seg_n       <= 8'hFF;
            seg7_decode <= 6'h3F;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_sched.sv
// Bench for seg7_scan_sched with SCAN_DIV=8, BLANK_CYC=2, NUM_DIGITS=6.
// Expected drive slots ({seg7_decode, seg_n}) are queued by the stimulus
// process; a monitor pops one entry at the start of every drive slot and
// also checks slot length/stability and the 48-cycle frame period.
module tb_seg7_scan_sched;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [4:0] wr_data;
  logic [7:0] seg_n;
  logic [5:0] seg7_decode;
  logic       frame_tick;

  int n_checks = 0;
  int n_pass   = 0;

  logic [13:0] exp_q[$];
  logic [4:0]  mram [6];

  seg7_scan_sched #(
    .NUM_DIGITS(6),
    .SCAN_DIV  (8),
    .BLANK_CYC (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .seg_n      (seg_n),
    .seg7_decode(seg7_decode),
    .frame_tick (frame_tick)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Hand-written table from the segment chart, active-high {a..g}.
  function automatic logic [6:0] tb_hex(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1111110;
      4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;
      4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;
      4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;
      4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;
      4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;
      4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;
      default: return 7'b1000111;
    endcase
  endfunction

  function automatic logic [13:0] exp_slot(input int i, input logic [4:0] c, input bit blank);
    logic [5:0] d;
    logic [7:0] s;
    d = ~(6'b000001 << i);
    s = blank ? 8'hFF : ~{tb_hex(c[3:0]), c[4]};
    return {d, s};
  endfunction

  task automatic push_frame();
    bit blank;
    for (int i = 0; i < 6; i++) begin
      blank = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (i != 0) begin
        blank = 1'b1;
        for (int j = i; j < 6; j++) if (mram[j] != 5'd0) blank = 1'b0;
      end
`endif
      exp_q.push_back(exp_slot(i, mram[i], blank));
    end
  endtask

  // ---------------- driver tasks (called at posedge+2) ----------------
  task automatic write_digit(input logic [2:0] a, input logic [4:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    if (a < 3'd6) mram[a] = d;
    @(posedge clk); #2;
    wr_en = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  // Wait until the monitor has consumed the queue down to 'lim' entries.
  task automatic wait_q(input int lim, input int budget);
    int k;
    k = 0;
    while (exp_q.size() > lim && k < budget) begin
      step();
      k++;
    end
    if (exp_q.size() > lim) begin
      check("wait_q_timeout", 16'(exp_q.size()), 16'(lim));
      exp_q.delete();
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [5:0]  prev_dec = 6'h3F;
  int          run_len  = 0;
  logic [13:0] run_val;
  bit          run_chg, run_cut;
  int          cyc = 0;
  int          last_tick = 0;
  bit          tick_ok = 1'b0;
  logic [13:0] got, want;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_dec = 6'h3F;
      run_len  = 0;
      tick_ok  = 1'b0;
    end else begin
      if (!enable) tick_ok = 1'b0;
      if (frame_tick) begin
        if (tick_ok) check("frame_period", 16'(cyc - last_tick), 16'd48);
        last_tick = cyc;
        tick_ok   = enable;
      end

      got = {seg7_decode, seg_n};
      if (seg7_decode != 6'h3F && prev_dec == 6'h3F) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL slot_unexpected: got %h with empty expected queue (t=%0t)", got, $time);
        end else begin
          want = exp_q.pop_front();
          check("slot_value", 16'(got), 16'(want));
        end
        run_len = 1;
        run_val = got;
        run_chg = 1'b0;
        run_cut = !enable;
      end else if (seg7_decode != 6'h3F) begin
        run_len++;
        if (got != run_val) run_chg = 1'b1;
        if (!enable) run_cut = 1'b1;
      end else if (prev_dec != 6'h3F) begin
        if (!run_cut) check("slot_len_stable", {run_chg, 15'(run_len)}, {1'b0, 15'd6});
        run_len = 0;
      end
      prev_dec = seg7_decode;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst     = 1'b1;
    enable  = 1'b0;
    wr_en   = 1'b0;
    wr_addr = 3'd0;
    wr_data = 5'd0;
    for (int i = 0; i < 6; i++) mram[i] = 5'd0;

    step();
    step();
    check("reset_seg_n", 16'(seg_n), 16'h00FF);
    check("reset_decode", 16'(seg7_decode), 16'h003F);
    check("reset_tick", 16'(frame_tick), 16'h0000);
    rst = 1'b0;
    step();

    // Digits 0..5 = 1..6, then out-of-range writes that must be ignored.
    for (int i = 0; i < 6; i++) write_digit(3'(i), 5'(i + 1));
    write_digit(3'd7, 5'h08);
    write_digit(3'd6, 5'h08);
    step();
    check("idle_dark", {seg7_decode, seg_n, 2'b00}, {6'h3F, 8'hFF, 2'b00});

    // Two frames with the original contents.
    push_frame();
    push_frame();
    enable = 1'b1;
    step();
    check("start_tick", 16'(frame_tick), 16'h0001);
    step();
    check("start_tick_width", 16'(frame_tick), 16'h0000);

    // Second frame, digit 2 in drive: overwrite it with A + dp.
    wait_q(3, 200);
    check("digit2_driving", 16'(seg7_decode), 16'h003B);
    write_digit(3'd2, 5'h1A);
    check("digit2_old_kept", 16'(seg_n), 16'(8'b00001101));
    push_frame();
    check("digitA_code", 16'(exp_slot(2, mram[2], 1'b0)), {6'h3B, 8'b00010000});

    // Third frame shows the new digit 2; drop enable after digit 2.
    wait_q(3, 200);
    enable = 1'b0;
    exp_q.delete();
    step();
    check("disable_dark", {seg7_decode, seg_n, 2'b00}, {6'h3F, 8'hFF, 2'b00});
    step();
    step();
    check("disable_still_dark", {seg7_decode, seg_n, 2'b00}, {6'h3F, 8'hFF, 2'b00});

    // Re-enable: restart at digit 0, RAM intact.
    push_frame();
    push_frame();
    enable = 1'b1;
    step();
    check("restart_tick", 16'(frame_tick), 16'h0001);
    wait_q(4, 200);

    // Asynchronous reset in the middle of a drive slot.
    rst = 1'b1;
    #1;
    check("async_rst_seg_n", 16'(seg_n), 16'h00FF);
    check("async_rst_decode", 16'(seg7_decode), 16'h003F);
    exp_q.delete();
    for (int i = 0; i < 6; i++) mram[i] = 5'd0;
    push_frame();
    @(posedge clk); #2;
    rst = 1'b0;
    step();
    check("post_rst_tick", 16'(frame_tick), 16'h0001);
    wait_q(0, 200);

    // Leading-zero pattern {5..0} = 0,0,0,4,0,7.
    enable = 1'b0;
    step();
    write_digit(3'd2, 5'h04);
    write_digit(3'd0, 5'h07);
    push_frame();
    enable = 1'b1;
    wait_q(0, 200);
    enable = 1'b0;
    step();
    step();
    check("final_dark", {seg7_decode, seg_n, 2'b00}, {6'h3F, 8'hFF, 2'b00});
    check("queue_drained", 16'(exp_q.size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop in case something wedges the stimulus process.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
